// File: rtl/i2s_receiver.sv
// ---------------------------------------------------------------------------
// i2s_receiver
//
// ADC-side I2S slave receiver. BCLK, LRCLK and SDATA are oversampled in the
// clk_i domain through 3-flop chains. One left/right sample pair is
// deserialized per frame and presented with a one-cycle valid pulse.
//
// Parameters:
//   DATA_WIDTH  bits captured per channel, MSB first (1..32)
//   I2S_FORMAT  "True" = I2S (MSB one BCLK after LRCLK edge),
//               anything else = left-justified (MSB on first BCLK)
//
// Ports:
//   clk_i       system clock (>= 8x BCLK)
//   rst_n_i     asynchronous active-low reset
//   bclk_i      I2S bit clock (asynchronous)
//   lrclk_i     I2S word select (asynchronous), 0 = left, 1 = right
//   sdata_i     serial data (asynchronous)
//   err_clr_i   synchronous clear of err_o
//   left_o      last complete left sample
//   right_o     last complete right sample
//   data_o      mono word for the downstream transmitter
//   data_val_o  one-cycle pulse; left_o/right_o/data_o updated this cycle
//   err_o       sticky framing error (short or long word)
//
// Configuration macro:
//   I2S_RX_MONO_SUM_EN  defined: data_o = (left + right) >>> 1
//                       undefined: data_o = left_o
// ---------------------------------------------------------------------------
module i2s_receiver #(
  parameter int DATA_WIDTH = 16,
  parameter     I2S_FORMAT = "True"
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  bclk_i,
  input  logic                  lrclk_i,
  input  logic                  sdata_i,
  input  logic                  err_clr_i,
  output logic [DATA_WIDTH-1:0] left_o,
  output logic [DATA_WIDTH-1:0] right_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_val_o,
  output logic                  err_o
);

  localparam bit         IS_I2S    = (I2S_FORMAT == "True");
  localparam logic [5:0] DW6       = 6'(DATA_WIDTH);
  localparam logic [5:0] LAST_SLOT = IS_I2S ? DW6 : (DW6 - 6'd1);

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  logic [2:0]            bclk_d;
  logic [2:0]            lrclk_d;
  logic [2:0]            sdata_d;

  state_t                state, state_n;
  logic [5:0]            slot_cnt, slot_n;
  logic [5:0]            bit_cnt, bcnt_n;
  logic [DATA_WIDTH-1:0] shift_q, shift_n;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_n;
  logic [DATA_WIDTH-1:0] left_n, right_n, data_n;
  logic                  val_n;
  logic                  err_set;

  logic [5:0]            s_slot, s_bcnt;
  logic [DATA_WIDTH-1:0] s_shift, padded, word;

  logic bclk_rise, lr_rise, lr_fall, lr_edge;

  // Slot positions that carry payload bits for the selected format.
  function automatic logic in_window(input logic [5:0] s);
    if (IS_I2S) return (s >= 6'd1) && (s <= DW6);
    else        return (s < DW6);
  endfunction

`ifdef I2S_RX_MONO_SUM_EN
  // Sum at DATA_WIDTH+1 bits, halve arithmetically, keep the low DATA_WIDTH.
  function automatic logic [DATA_WIDTH-1:0] mono_mix(
    input logic signed [DATA_WIDTH-1:0] l,
    input logic signed [DATA_WIDTH-1:0] r
  );
    logic signed [DATA_WIDTH:0] sum;
    sum = $signed({l[DATA_WIDTH-1], l}) + $signed({r[DATA_WIDTH-1], r});
    return sum[DATA_WIDTH:1];
  endfunction
`endif

  // Input synchronizer stage: edges decoded on the two oldest taps.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bclk_d  <= '0;
      lrclk_d <= '0;
      sdata_d <= '0;
    end else begin
      bclk_d  <= {bclk_d[1:0],  bclk_i};
      lrclk_d <= {lrclk_d[1:0], lrclk_i};
      sdata_d <= {sdata_d[1:0], sdata_i};
    end
  end

  assign bclk_rise = (bclk_d[2:1]  == 2'b01);
  assign lr_rise   = (lrclk_d[2:1] == 2'b01);
  assign lr_fall   = (lrclk_d[2:1] == 2'b10);
  assign lr_edge   = lr_rise | lr_fall;

  // Frame decode: an LRCLK edge is handled first, so a coincident BCLK rise
  // is evaluated against the freshly cleared slot/shift state (slot 0).
  always_comb begin
    state_n  = state;
    slot_n   = slot_cnt;
    bcnt_n   = bit_cnt;
    shift_n  = shift_q;
    shadow_n = shadow_q;
    left_n   = left_o;
    right_n  = right_o;
    data_n   = data_o;
    val_n    = 1'b0;
    err_set  = 1'b0;
    s_slot   = slot_cnt;
    s_bcnt   = bit_cnt;
    s_shift  = shift_q;
    word     = '0;
    // Zero-pad the missing LSBs of a word cut short by an LRCLK edge.
    padded   = shift_q << (DW6 - bit_cnt);

    if (lr_edge) begin
      if (state != SYNC && bit_cnt != DW6) begin
        err_set = 1'b1;
        if (state == LEFT) begin
          shadow_n = padded;
        end else begin
          left_n  = shadow_q;
          right_n = padded;
          val_n   = 1'b1;
        end
      end
      if (lr_fall)             state_n = LEFT;
      else if (state == LEFT)  state_n = RIGHT;
      s_slot  = '0;
      s_bcnt  = '0;
      s_shift = '0;
      slot_n  = '0;
      bcnt_n  = '0;
      shift_n = '0;
    end

    if (bclk_rise && state_n != SYNC) begin
      slot_n = (s_slot == 6'd63) ? s_slot : (s_slot + 6'd1);
      // Reaching slot 33 means more BCLKs than any legal channel carries.
      if (s_slot == 6'd32) err_set = 1'b1;
      if (in_window(s_slot)) begin
        word    = (s_shift << 1) | DATA_WIDTH'(sdata_d[2]);
        shift_n = word;
        bcnt_n  = s_bcnt + 6'd1;
        if (s_slot == LAST_SLOT) begin
          if (state_n == LEFT) begin
            shadow_n = word;
          end else begin
            left_n  = shadow_n;
            right_n = word;
            val_n   = 1'b1;
          end
        end
      end
    end

    if (val_n) begin
`ifdef I2S_RX_MONO_SUM_EN
      data_n = mono_mix(left_n, right_n);
`else
      data_n = left_n;
`endif
    end
  end

  // Registered state and outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= SYNC;
      slot_cnt   <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      shadow_q   <= '0;
      left_o     <= '0;
      right_o    <= '0;
      data_o     <= '0;
      data_val_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state      <= state_n;
      slot_cnt   <= slot_n;
      bit_cnt    <= bcnt_n;
      shift_q    <= shift_n;
      shadow_q   <= shadow_n;
      left_o     <= left_n;
      right_o    <= right_n;
      data_o     <= data_n;
      data_val_o <= val_n;
      if (err_set)        err_o <= 1'b1;
      else if (err_clr_i) err_o <= 1'b0;
    end
  end

endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

ADC-side I2S slave receiver, directly upstream of the DAC-side transmitter in the audio path. It oversamples externally generated BCLK/LRCLK/SDATA in the system clock domain and deserializes one left/right sample pair per frame. The result is presented as a parallel word with a one-cycle valid pulse on the same `data`/`data_val` contract the transmitter consumes. It also provides a coherent stereo pair and a sticky framing-error flag.

## Interface
Parameters:
- `DATA_WIDTH`, 16: bits captured per channel, MSB first, 1..32.
- `I2S_FORMAT`, "True": "True" means I2S (MSB one BCLK after LRCLK edge); any other value means left-justified (MSB on first BCLK after edge).

Ports:
- `clk_i` in 1: system clock; must be ≥ 8× BCLK.
- `rst_n_i` in 1: asynchronous active-low reset.
- `bclk_i` in 1: I2S bit clock, asynchronous.
- `lrclk_i` in 1: I2S word select, asynchronous; 0 = left, 1 = right.
- `sdata_i` in 1: serial data from ADC, asynchronous.
- `left_o` out DATA_WIDTH: last complete left sample.
- `right_o` out DATA_WIDTH: last complete right sample.
- `data_o` out DATA_WIDTH: mono word for the transmitter.
- `data_val_o` out 1: one-cycle pulse; all three data outputs updated this cycle.
- `err_o` out 1: sticky framing error.
- `err_clr_i` in 1: synchronous clear of `err_o`.

## Operation
- `bclk_i`, `lrclk_i`, and `sdata_i` each pass through an identical 3-flop chain (`*_d[2:0]`).
- Edges are decoded on `[2:1]`: `01` is a rise, `10` is a fall. `sdata_d[2]` is the sampled bit.
- The FSM has three states: SYNC, LEFT, RIGHT. Reset enters SYNC.
- SYNC -> LEFT on an LRCLK fall. Rises before the first LRCLK fall are ignored.
- LEFT -> RIGHT on an LRCLK rise.
- RIGHT -> LEFT on an LRCLK fall.
- `slot_cnt` (6 bit) clears on every LRCLK edge. It increments on each BCLK rise in LEFT/RIGHT and saturates at 63.
- Capture window:
  - I2S: slots 1..DATA_WIDTH (slot 0 is the previous word's LSB).
  - Left-justified: slots 0..DATA_WIDTH-1.
  - Bits outside the window are ignored.
- Shift register: MSB first, shifting left.
- After the last window bit of LEFT, the word goes to a left shadow register. Outputs are not touched.
- After the last window bit of RIGHT, `left_o` is loaded from the shadow and `right_o` from the shift register. `data_o` is updated and `data_val_o` pulses.
- Short word: an LRCLK edge arrives before the window completes. Remaining LSBs are zero-padded and the word is finalized on that edge. `err_o` is set.
  - A short RIGHT word still produces the `data_val_o` pulse.
- Long word: slot_cnt reaches 33 within one channel. `err_o` is set and the word is unaffected.
- `err_o` is set-dominant when a set and `err_clr_i` coincide.
- Reset mid-frame:
  - Outputs go to 0, the shadow and shift registers clear, FSM returns to SYNC.
  - The first pulse after reset comes only after a full LEFT+RIGHT.

## Timing
- Reset values: `left_o`/`right_o`/`data_o` = 0, `data_val_o` = 0, `err_o` = 0.
- Input-to-detect latency: 3 clk_i after the pin edge.
- `data_val_o` asserts 1 clk_i after the cycle the final RIGHT bit is sampled. Outputs are valid in that same cycle and held until the next pulse.
- At most one pulse per LRCLK period. Minimum spacing between pulses is 2 × DATA_WIDTH BCLK periods.
- An LRCLK edge and a BCLK rise decoded in the same cycle: the edge is processed first and the rise counts as slot 0 of the new word.
- Short-word finalization pulses 1 clk_i after the LRCLK edge is decoded.

## Configuration
- `I2S_RX_MONO_SUM_EN` defined: `data_o` = (sign-extended left + sign-extended right) >>> 1.
  - Computed at DATA_WIDTH+1 bits, arithmetic shift, truncated to DATA_WIDTH. No overflow is possible.
- `I2S_RX_MONO_SUM_EN` undefined: `data_o` = `left_o` (the sum adder is not built).

## Test plan
- I2S format, DATA_WIDTH=16, 32-slot words, left=16'h8001, right=16'h7FFE -> one pulse per frame; left_o=8001, right_o=7FFE; data_o=8001 (macro off) or 16'hFFFF (macro on); err_o=0.
- Left-justified format, left=16'hA5A5, right=16'h5A5A -> exact values captured, no off-by-one shift.
- RIGHT word cut at 10 BCLKs, right bits 16'hFFFF -> right_o=16'hFFC0, pulse 1 clk after the LRCLK fall, err_o=1; err_clr_i clears it.
- 40-slot channel -> err_o=1, captured data still correct.
- Reset asserted mid-LEFT -> outputs 0 immediately; no pulse for the partial frame; the first pulse follows the next complete frame.
- Stream starts in the middle of a RIGHT word -> no pulse until the LRCLK fall; the first pair is correct.
